// File: rtl/cnn_maxpool.sv
// 2x2 stride-2 max-pool of two Layer-0 maps (L0K0, L0K1) into two Layer-1 maps (L1K0, L1K1).
// Define MAXPOOL_RELU_EN to clamp negative maxima to zero before they are written.
module cnn_maxpool #(
  parameter int IMG_W  = 64,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [11:0]       caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [11:0]       caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  localparam int HW = IMG_W / 2;
  localparam int CW = $clog2(HW);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     r_q, c_q;
  logic              k_q;
  logic [DATA_W-1:0] max_q, max_nx, wr_val;
  logic              last_px;
  logic [11:0]       base_rd;
  logic [2:0]        rd_sel, wr_sel;

  // Ties keep the earlier value: only a strictly greater sample replaces it.
  always_comb begin
    max_nx = ($signed(cdata_rd) > $signed(max_q)) ? cdata_rd : max_q;
`ifdef MAXPOOL_RELU_EN
    wr_val = max_nx[DATA_W-1] ? '0 : max_nx;
`else
    wr_val = max_nx;
`endif
  end

  always_comb begin
    last_px = (r_q == CW'(HW - 1)) && (c_q == CW'(HW - 1));
    base_rd = (12'(r_q) * 12'(2 * IMG_W)) + (12'(c_q) << 1);
    rd_sel  = k_q ? 3'b010 : 3'b001;
    wr_sel  = k_q ? 3'b100 : 3'b011;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    csel     = 3'b000;
    caddr_rd = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RD0;
      end
      RD0: begin
        crd      = 1'b1;
        csel     = rd_sel;
        caddr_rd = base_rd;
        state_d  = RD1;
      end
      RD1: begin
        crd      = 1'b1;
        csel     = rd_sel;
        caddr_rd = base_rd + 12'd1;
        state_d  = RD2;
      end
      RD2: begin
        crd      = 1'b1;
        csel     = rd_sel;
        caddr_rd = base_rd + 12'(IMG_W);
        state_d  = RD3;
      end
      RD3: begin
        crd      = 1'b1;
        csel     = rd_sel;
        caddr_rd = base_rd + 12'(IMG_W + 1);
        state_d  = CAP;
      end
      CAP: begin
        csel    = rd_sel;
        state_d = WR;
      end
      WR: begin
        cwr     = 1'b1;
        csel    = wr_sel;
        state_d = (last_px && k_q) ? DONE : RD0;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write address/data are registered in CAP so they hold through idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= 1'b0;
      max_q    <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      case (state_q)
        RD1:      max_q <= cdata_rd;
        RD2, RD3: max_q <= max_nx;
        CAP: begin
          cdata_wr <= wr_val;
          caddr_wr <= (12'(r_q) * 12'(HW)) + 12'(c_q);
        end
        WR: begin
          if (c_q == CW'(HW - 1)) begin
            c_q <= '0;
            if (r_q == CW'(HW - 1)) begin
              r_q <= '0;
              k_q <= ~k_q;
            end else begin
              r_q <= r_q + 1'b1;
            end
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_maxpool.sv
// Self-checking bench for cnn_maxpool: memory model, reference max-pool scoreboard, scenario tasks.
module tb_cnn_maxpool;

  localparam int IMG_W  = 64;
  localparam int DATA_W = 20;
  localparam int HW     = IMG_W / 2;
  localparam int PASS_BUSY = 2 * HW * HW * 6 + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, crd, cwr;
  logic [11:0]       caddr_rd, caddr_wr;
  logic [DATA_W-1:0] cdata_rd = '0;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  always #5 clk = ~clk;

  cnn_maxpool #(.IMG_W(IMG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  logic [DATA_W-1:0] mem0 [4096];
  logic [DATA_W-1:0] mem1 [4096];

  typedef struct packed {
    logic [2:0]        sel;
    logic [11:0]       addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int busy_cnt = 0, done_cnt = 0, both_cnt = 0;

  // Result memory: read data appears the cycle after crd.
  always @(posedge clk)
    if (crd) cdata_rd <= (csel == 3'b010) ? mem1[caddr_rd] : mem0[caddr_rd];

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (crd && cwr) both_cnt++;
    if (cwr) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got sel=%0h addr=%0d data=%h, required no write",
                 csel, caddr_wr, cdata_wr);
      end else begin
        e = sb.pop_front();
        if (csel !== e.sel || caddr_wr !== e.addr || cdata_wr !== e.data) begin
          bad++;
          $display("FAIL write_data: got sel=%0h addr=%0d data=%h, required sel=%0h addr=%0d data=%h",
                   csel, caddr_wr, cdata_wr, e.sel, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] ref_px(int k, int r, int c);
    int v[4];
    int m;
    int a;
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 4; i++) begin
      a = (2 * r + i / 2) * IMG_W + 2 * c + (i % 2);
      w = (k != 0) ? mem1[a] : mem0[a];
      v[i] = $signed(w);
    end
    m = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m[DATA_W-1:0];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = DATA_W'($urandom);
      mem1[i] = DATA_W'($urandom);
    end
  endtask

  task automatic load_sb();
    exp_t e;
    sb.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < HW; r++)
        for (int c = 0; c < HW; c++) begin
          e.sel  = (k != 0) ? 3'b100 : 3'b011;
          e.addr = 12'(r * HW + c);
          e.data = ref_px(k, r, c);
          sb.push_back(e);
        end
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  // Returns at the falling edge of the first busy cycle (RD0 of pixel 0).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PASS_BUSY + 500; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_pass_end(string name);
    bit ok;
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got no done pulse, required one", name);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
    end
    total++;
    if (busy_cnt !== PASS_BUSY) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_cnt, PASS_BUSY);
    end
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL %s_writes_missing: got %0d outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, crd, cwr, csel} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b crd=%b cwr=%b csel=%b, required all 0",
               busy, done, crd, cwr, csel);
    end
    total++;
    if (caddr_rd !== 12'd0 || caddr_wr !== 12'd0) begin
      bad++;
      $display("FAIL reset_addr: got rd=%0d wr=%0d, required 0 0", caddr_rd, caddr_wr);
    end
    total++;
    if (cdata_wr !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h, required 0", cdata_wr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || csel !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b csel=%b, required 0 000", busy, csel);
    end
  endtask

  task automatic test_first_window();
    int ea[4];
    ea = '{0, 1, 64, 65};
    fill_random();
    mem0[0] = 20'h00100; mem0[1] = 20'h00300; mem0[64] = 20'h00200; mem0[65] = 20'h00050;
    load_sb();
    clear_counts();
    pulse_start();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc <= 4) begin
        total++;
        if (crd !== 1'b1 || cwr !== 1'b0 || caddr_rd !== 12'(ea[cyc-1]) || csel !== 3'b001) begin
          bad++;
          $display("FAIL first_read%0d: got crd=%b cwr=%b addr=%0d csel=%b, required 1 0 %0d 001",
                   cyc, crd, cwr, caddr_rd, csel, ea[cyc-1]);
        end
      end
      if (cyc == 6) begin
        total++;
        if (cwr !== 1'b1 || crd !== 1'b0 || caddr_wr !== 12'd0 || cdata_wr !== 20'h00300 || csel !== 3'b011) begin
          bad++;
          $display("FAIL first_write: got cwr=%b crd=%b addr=%0d data=%h csel=%b, required 1 0 0 00300 011",
                   cwr, crd, caddr_wr, cdata_wr, csel);
        end
      end
    end
    check_pass_end("first_window");
  endtask

  task automatic test_full_pass();
    fill_random();
    load_sb();
    clear_counts();
    pulse_start();
    check_pass_end("full_pass");
  endtask

  task automatic test_negative_boundary();
    int ea[4];
    logic [DATA_W-1:0] neg_exp;
    ea = '{4030, 4031, 4094, 4095};
`ifdef MAXPOOL_RELU_EN
    neg_exp = 20'h00000;
`else
    neg_exp = 20'hFFF80;
`endif
    fill_random();
    mem1[0] = 20'hFFF00; mem1[1] = 20'hFFE00; mem1[64] = 20'hFFF80; mem1[65] = 20'hFFC00;
    load_sb();
    clear_counts();
    pulse_start();
    for (int cyc = 1; cyc <= 6150; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc >= 6139 && cyc <= 6142) begin
        total++;
        if (crd !== 1'b1 || caddr_rd !== 12'(ea[cyc-6139]) || csel !== 3'b001) begin
          bad++;
          $display("FAIL corner_read: got crd=%b addr=%0d csel=%b, required 1 %0d 001",
                   crd, caddr_rd, csel, ea[cyc-6139]);
        end
      end
      if (cyc == 6144) begin
        total++;
        if (cwr !== 1'b1 || caddr_wr !== 12'd1023 || csel !== 3'b011) begin
          bad++;
          $display("FAIL corner_write: got cwr=%b addr=%0d csel=%b, required 1 1023 011",
                   cwr, caddr_wr, csel);
        end
      end
      if (cyc == 6150) begin
        total++;
        if (cwr !== 1'b1 || caddr_wr !== 12'd0 || csel !== 3'b100 || cdata_wr !== neg_exp) begin
          bad++;
          $display("FAIL negative_window: got cwr=%b addr=%0d csel=%b data=%h, required 1 0 100 %h",
                   cwr, caddr_wr, csel, cdata_wr, neg_exp);
        end
      end
    end
    check_pass_end("negative_boundary");
  endtask

  task automatic test_reset_abort();
    fill_random();
    load_sb();
    clear_counts();
    pulse_start();
    repeat (4999) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    total++;
    if (busy !== 1'b0 || crd !== 1'b0 || cwr !== 1'b0 || csel !== 3'b000) begin
      bad++;
      $display("FAIL abort_state: got busy=%b crd=%b cwr=%b csel=%b, required 0 0 0 000",
               busy, crd, cwr, csel);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: got done_count=%0d busy=%b, required 0 0", done_cnt, busy);
    end
    fill_random();
    load_sb();
    clear_counts();
    pulse_start();
    check_pass_end("after_abort");
  endtask

  task automatic test_start_while_busy();
    fill_random();
    load_sb();
    clear_counts();
    pulse_start();
    repeat (98) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5900) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_pass_end("restart_ignored");
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      bad++;
      $display("FAIL restart_idle: got busy=%b done_count=%0d, required 0 1", busy, done_cnt);
    end
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL rd_wr_overlap: got %0d cycles, required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_full_pass();
    test_negative_boundary();
    test_reset_abort();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_maxpool.md
CNN_MAXPOOL -- requirements
Module: cnn_maxpool

Interface
REQ-001 SHALL have parameter IMG_W, default 64: Layer-0 map width and height in pixels.
REQ-002 SHALL have parameter DATA_W, default 20: pixel width, signed 4.16 fixed point.
REQ-003 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to pool both Layer-0 maps.
REQ-006 SHALL have port busy, output, 1: high while the block owns the result memory.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when both Layer-1 maps are written.
REQ-008 SHALL have port crd, output, 1: result-memory read enable.
REQ-009 SHALL have port caddr_rd, output, 12: read address, row*IMG_W+col.
REQ-010 SHALL have port cdata_rd, input, DATA_W: read data, valid in the cycle after crd.
REQ-011 SHALL have port cwr, output, 1: result-memory write enable.
REQ-012 SHALL have port caddr_wr, output, 12: write address, row*(IMG_W/2)+col.
REQ-013 SHALL have port cdata_wr, output, DATA_W: write data.
REQ-014 SHALL have port csel, output, 3: memory select; 000 none, 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1.

Function
REQ-015 SHALL implement FSM states IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE.
REQ-016 SHALL leave IDLE for RD0 on start=1; start is ignored in every other state.
REQ-017 SHALL, for output pixel (r,c), r,c in 0..IMG_W/2-1, read in RD0..RD3 the inputs (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1) in that order, crd=1, one address per cycle.
REQ-018 SHALL capture cdata_rd in RD1, RD2, RD3 and CAP, one cycle after the matching address.
REQ-019 SHALL keep a running maximum by signed DATA_W comparison; on ties the earlier value is kept (same value either way).
REQ-020 SHALL in WR drive cwr=1, crd=0, caddr_wr=r*(IMG_W/2)+c, cdata_wr=maximum; 6 cycles per output pixel.
REQ-021 SHALL never assert crd and cwr in the same cycle.
REQ-022 SHALL drive csel=001 during reads and 011 during writes for kernel 0, and 010/100 for kernel 1; csel=000 in IDLE and DONE.
REQ-023 SHALL scan c fastest, then r; after (31,31) of kernel 0, continue at (0,0) of kernel 1 with no idle cycle.
REQ-024 SHALL after WR of (31,31) of kernel 1 enter DONE, pulse done=1 for one cycle, then return to IDLE.
REQ-025 SHALL hold busy=1 from the cycle after start is accepted through the DONE cycle inclusive; total 2*1024*6+1 = 12289 busy cycles at IMG_W=64.
REQ-026 SHALL hold caddr_wr and cdata_wr at their last values when cwr=0.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, drive the next cycle: state IDLE, busy=0, done=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, csel=000, counters and maximum cleared.
REQ-028 SHALL give reset priority over start and abandon any pass in progress; no further write occurs and done is not pulsed.

Configuration
REQ-029 SHALL, with macro MAXPOOL_RELU_EN defined, write 0 instead of a negative maximum (bit DATA_W-1 set).
REQ-030 SHALL, without MAXPOOL_RELU_EN, write the signed maximum unchanged, negative values included.

Verification
REQ-031 SHALL check: reset, start pulse, L0K0 window at (0,0)/(0,1)/(64,...) = 0x00100,0x00300,0x00200,0x00050 -> first write caddr_wr=0, cdata_wr=0x00300, csel=011, 6 cycles after start accept.
REQ-032 SHALL check: full random 64x64 L0K0/L0K1 maps -> 1024 writes each to L1K0/L1K1 matching a reference max-pool; done pulses once, 12289 busy cycles.
REQ-033 SHALL check: window all negative 0xFFF00,0xFFE00,0xFFF80,0xFFC00 -> 0xFFF80 without MAXPOOL_RELU_EN, 0x00000 with it.
REQ-034 SHALL check: reset asserted at cycle 5000 of a pass -> next cycle busy=0, crd=0, cwr=0, csel=000; a following start runs a full pass correctly.
REQ-035 SHALL check: start pulsed again while busy -> ignored, exactly one done pulse; crd and cwr never both high in any cycle.
REQ-036 SHALL check: boundary window (31,31) reads addresses 4030, 4031, 4094, 4095 and writes caddr_wr=1023.
